// File: rtl/data_mem_lsu_pkg.sv
// data_mem_lsu_pkg: access-size encodings, LSU FSM states and the load-extension helper.
package data_mem_lsu_pkg;
    localparam logic [1:0] MEM_SZ_B = 2'b00;
    localparam logic [1:0] MEM_SZ_H = 2'b01;
    localparam logic [1:0] MEM_SZ_W = 2'b10;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    // Fill bit for the upper part of a byte/half load: the lane's top bit, or 0 when unsigned.
    function automatic logic ext_fill(input logic [1:0] size, input logic uns, input logic b7, input logic b15);
        return !uns && (size == MEM_SZ_B ? b7 : b15);
    endfunction
endpackage

// File: rtl/data_mem_lsu_if.sv
// data_mem_lsu_if: request/response handshake bundle between the MEM stage and the LSU.
interface data_mem_lsu_if #(parameter int XLEN = 32, parameter int ADDR_W = 32);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [XLEN-1:0]   rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_lsu_byte_ram.sv
// data_mem_lsu_byte_ram: DEPTH x XLEN word RAM with per-byte-lane write enables and registered read.
module data_mem_lsu_byte_ram #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic [XLEN/8-1:0]        we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [XLEN-1:0]          wdata,
    output logic [XLEN-1:0]          rdata
);
    logic [XLEN-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < XLEN / 8; i++)
                if (we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/data_mem_lsu.sv
// data_mem_lsu: byte-addressed data memory with load/store front end (B/H/W, sign/zero extend,
// misalign and range faults); one outstanding request through IDLE -> ACCESS -> RESP.
module data_mem_lsu
    import data_mem_lsu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    data_mem_lsu_if.slave bus
);
    localparam int LANES = XLEN / 8;
    localparam int LB    = $clog2(LANES);
    localparam int IW    = $clog2(DEPTH);

    state_t            state;
    logic              ready_q, valid_q, rerr_q, ld_q;
    logic              we_q, uns_q, err_q;
    logic [1:0]        size_q;
    logic [LB-1:0]     off_q;
    logic [IW-1:0]     idx_q;
    logic [XLEN-1:0]   wdata_q;
    logic [LB-1:0]     off;
    logic              req_err, fill;
    logic [LANES-1:0]  lanes, ram_we;
    logic [XLEN-1:0]   lane_data, rd_word, sh;

    assign off = bus.req_addr[LB-1:0];
    // Any address bit above the word index makes the access out of range.
    assign req_err = bus.req_size == 2'b11
                  || (bus.req_size == MEM_SZ_H && bus.req_addr[0])
                  || (bus.req_size == MEM_SZ_W && off != '0)
                  || (bus.req_addr >> (LB + IW)) != '0;

    assign lanes     = size_q == MEM_SZ_B ? LANES'(1) << off_q :
                       size_q == MEM_SZ_H ? LANES'(3) << off_q : '1;
    assign lane_data = size_q == MEM_SZ_B ? {LANES{wdata_q[7:0]}} :
                       size_q == MEM_SZ_H ? {(LANES/2){wdata_q[15:0]}} : wdata_q;
    assign ram_we    = (state == ACCESS && we_q && !err_q) ? lanes : '0;

    data_mem_lsu_byte_ram #(.XLEN(XLEN), .DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .en    (state == ACCESS),
        .we    (ram_we),
        .addr  (idx_q),
        .wdata (lane_data),
        .rdata (rd_word)
    );

    // Good word loads always have offset 0, so the shifted word doubles as the word result.
    assign sh   = rd_word >> {off_q, 3'b000};
    assign fill = ext_fill(size_q, uns_q, sh[7], sh[15]);

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = valid_q;
    assign bus.rsp_err   = rerr_q;
    assign bus.rsp_rdata = !ld_q                ? '0 :
                           size_q == MEM_SZ_B   ? {{(XLEN-8){fill}}, sh[7:0]} :
                           size_q == MEM_SZ_H   ? {{(XLEN-16){fill}}, sh[15:0]} : sh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            rerr_q  <= 1'b0;
            ld_q    <= 1'b0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= MEM_SZ_B;
            off_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    we_q    <= bus.req_we;
                    uns_q   <= bus.req_unsigned;
                    size_q  <= bus.req_size;
                    err_q   <= req_err;
                    off_q   <= off;
                    idx_q   <= bus.req_addr[LB +: IW];
                    wdata_q <= bus.req_wdata;
                    ready_q <= 1'b0;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    valid_q <= 1'b1;
                    rerr_q  <= err_q;
                    ld_q    <= !we_q && !err_q;
                    state   <= RESP;
                end
                RESP: if (bus.rsp_ready) begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_lsu.sv
// tb_data_mem_lsu: directed vector table, reset/backpressure sequences and randomized traffic
// checked against a byte-array memory model.
module tb_data_mem_lsu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [7:0] mb [256];

    data_mem_lsu_if #(.XLEN(32), .ADDR_W(32)) bus ();

    data_mem_lsu #(.XLEN(32), .DEPTH(1024), .ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: bytes little-endian in mb[], faults from alignment/range/size rules.
    task automatic model(input logic we, input logic [1:0] sz, input logic un, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int n;
        logic [31:0] v;
        n  = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
        er = sz == 2'd3 || (a % n) != 0 || a >= 32'h1000;
        rd = '0;
        if (er) return;
        if (we) begin
            for (int i = 0; i < n; i++) mb[int'(a) + i] = wd[8*i +: 8];
        end else begin
            v = '0;
            for (int i = 0; i < n; i++) v = v | (32'(mb[int'(a) + i]) << (8 * i));
            if (!un && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
            rd = v;
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] sz, input logic un, input logic [31:0] a,
                         input logic [31:0] wd);
        bus.req_we       = we;
        bus.req_size     = sz;
        bus.req_unsigned = un;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        bus.req_valid    = 1'b1;
    endtask

    task automatic xact(input logic we, input logic [1:0] sz, input logic un, input logic [31:0] a,
                        input logic [31:0] wd, input int hold, output logic [31:0] rd, output logic er);
        int k;
        @(negedge clk);
        chk("req_ready_idle", bus.req_ready, 1);
        drive(we, sz, un, a, wd);
        bus.rsp_ready = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("rsp_valid_after_accept", bus.rsp_valid, 0);
        k = 0;
        while (!bus.rsp_valid && k < 8) begin
            @(posedge clk); #1;
            k++;
        end
        chk("rsp_latency", k, 1);
        repeat (hold) begin
            @(posedge clk); #1;
        end
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk("back_to_idle", {bus.rsp_valid, bus.req_ready}, 2'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vt[$];
        logic [31:0] rd, exp_rd, r0;
        logic        er, exp_er;

        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        drive(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        bus.req_valid = 1'b0;

        vt.push_back('{"SW_40",   1'b1, 2'b10, 1'b0, 32'h40,   32'hDEADBEEF, 32'h0,        1'b0});
        vt.push_back('{"LW_40",   1'b0, 2'b10, 1'b0, 32'h40,   32'h0,        32'hDEADBEEF, 1'b0});
        vt.push_back('{"SB_41",   1'b1, 2'b00, 1'b0, 32'h41,   32'hAAAA5512, 32'h0,        1'b0});
        vt.push_back('{"LB_43",   1'b0, 2'b00, 1'b0, 32'h43,   32'h0,        32'hFFFFFFDE, 1'b0});
        vt.push_back('{"LBU_43",  1'b0, 2'b00, 1'b1, 32'h43,   32'h0,        32'h000000DE, 1'b0});
        vt.push_back('{"LB_41",   1'b0, 2'b00, 1'b0, 32'h41,   32'h0,        32'h00000012, 1'b0});
        vt.push_back('{"LW_40b",  1'b0, 2'b10, 1'b0, 32'h40,   32'h0,        32'hDEAD12EF, 1'b0});
        vt.push_back('{"LH_42",   1'b0, 2'b01, 1'b0, 32'h42,   32'h0,        32'hFFFFDEAD, 1'b0});
        vt.push_back('{"LHU_42",  1'b0, 2'b01, 1'b1, 32'h42,   32'h0,        32'h0000DEAD, 1'b0});
        vt.push_back('{"LW_uns",  1'b0, 2'b10, 1'b1, 32'h40,   32'h0,        32'hDEAD12EF, 1'b0});
        vt.push_back('{"SH_42",   1'b1, 2'b01, 1'b0, 32'h42,   32'h12347FFF, 32'h0,        1'b0});
        vt.push_back('{"LH_42b",  1'b0, 2'b01, 1'b0, 32'h42,   32'h0,        32'h00007FFF, 1'b0});
        vt.push_back('{"LHU_40",  1'b0, 2'b01, 1'b1, 32'h40,   32'h0,        32'h000012EF, 1'b0});
        vt.push_back('{"LW_41",   1'b0, 2'b10, 1'b0, 32'h41,   32'h0,        32'h0,        1'b1});
        vt.push_back('{"LH_43",   1'b0, 2'b01, 1'b0, 32'h43,   32'h0,        32'h0,        1'b1});
        vt.push_back('{"SW_1000", 1'b1, 2'b10, 1'b0, 32'h1000, 32'h0,        32'h0,        1'b1});
        vt.push_back('{"SW_41",   1'b1, 2'b10, 1'b0, 32'h41,   32'h11111111, 32'h0,        1'b1});
        vt.push_back('{"SZ11_40", 1'b1, 2'b11, 1'b0, 32'h40,   32'h22222222, 32'h0,        1'b1});
        vt.push_back('{"LW_40c",  1'b0, 2'b10, 1'b0, 32'h40,   32'h0,        32'h7FFF12EF, 1'b0});

        repeat (2) @(posedge clk);
        #1;
        chk("reset_req_ready", bus.req_ready, 1);
        chk("reset_rsp_valid", bus.rsp_valid, 0);
        chk("reset_rsp_rdata", bus.rsp_rdata, 0);
        chk("reset_rsp_err",   bus.rsp_err, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int w = 0; w < 64; w++) begin
            r0 = $urandom;
            model(1'b1, 2'b10, 1'b0, 32'(w * 4), r0, exp_rd, exp_er);
            xact(1'b1, 2'b10, 1'b0, 32'(w * 4), r0, 0, rd, er);
        end

        foreach (vt[i]) begin
            model(vt[i].we, vt[i].size, vt[i].uns, vt[i].addr, vt[i].wdata, exp_rd, exp_er);
            xact(vt[i].we, vt[i].size, vt[i].uns, vt[i].addr, vt[i].wdata, i % 3, rd, er);
            chk({vt[i].name, "_rdata"}, rd, vt[i].exp_rd);
            chk({vt[i].name, "_err"}, er, vt[i].exp_err);
        end

        // Backpressure: response held 5 cycles while a new store is presented and must wait.
        model(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, exp_rd, exp_er);
        @(negedge clk);
        drive(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        @(posedge clk); #1;
        drive(1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D);
        @(posedge clk); #1;
        chk("bp_valid", bus.rsp_valid, 1);
        chk("bp_rdata", bus.rsp_rdata, exp_rd);
        r0 = bus.rsp_rdata;
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_hold", {bus.rsp_valid, bus.req_ready, bus.rsp_err}, 3'b100);
            chk("bp_rdata_stable", bus.rsp_rdata, r0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk("bp_release_idle", {bus.rsp_valid, bus.req_ready}, 2'b01);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("bp_next_accepted", bus.req_ready, 0);
        model(1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, exp_rd, exp_er);
        @(posedge clk); #1;
        chk("bp_next_rsp", {bus.rsp_valid, bus.rsp_err}, 2'b10);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        model(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, exp_rd, exp_er);
        xact(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 0, rd, er);
        chk("bp_store_landed", rd, exp_rd);

        // Reset during RESP: response vanishes at once, the store already written stays.
        @(negedge clk);
        drive(1'b1, 2'b10, 1'b0, 32'h44, 32'h55AA55AA);
        model(1'b1, 2'b10, 1'b0, 32'h44, 32'h55AA55AA, exp_rd, exp_er);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        chk("rr_valid_before", bus.rsp_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("rr_async_valid", bus.rsp_valid, 0);
        chk("rr_async_ready", bus.req_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rr_no_response", bus.rsp_valid, 0);

        // Reset during ACCESS: store aborted before it reaches the RAM.
        @(negedge clk);
        drive(1'b1, 2'b10, 1'b0, 32'h48, 32'h0BADF00D);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("ra_in_access", bus.req_ready, 0);
        rst = 1'b1;
        #1;
        chk("ra_async_ready", bus.req_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ra_no_response", bus.rsp_valid, 0);
        model(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, exp_rd, exp_er);
        xact(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 0, rd, er);
        chk("rr_store_kept", rd, exp_rd);
        model(1'b0, 2'b10, 1'b0, 32'h48, 32'h0, exp_rd, exp_er);
        xact(1'b0, 2'b10, 1'b0, 32'h48, 32'h0, 0, rd, er);
        chk("ra_store_aborted", rd, exp_rd);

        for (int t = 0; t < 300; t++) begin
            logic        we, un;
            logic [1:0]  sz;
            logic [31:0] a, wd;
            we = 1'($urandom);
            un = 1'($urandom);
            sz = ($urandom % 16 == 0) ? 2'd3 : 2'($urandom % 3);
            a  = ($urandom % 10 == 0) ? ($urandom | 32'h1000) : 32'($urandom % 256);
            wd = $urandom;
            model(we, sz, un, a, wd, exp_rd, exp_er);
            xact(we, sz, un, a, wd, int'($urandom % 3), rd, er);
            chk("rand_rdata", rd, exp_rd);
            chk("rand_err", er, exp_er);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
